mpu_irq_queue: RTL and testbench
================================

Name: mpu_irq_queue

Overview:
Buffers interrupt events raised by the MPU datapath and issues them one at a time to the MPU interrupt controller. The controller receives a one-cycle irq pulse plus 64-bit data, and signals readiness on en. en drops after an irq and rises again once the event is committed. Sits directly upstream of the interrupt controller. Absorbs bursts the controller cannot take while en is low. Counts events lost to overflow.

Parameters:
DEPTH_LOG2, 2, log2 of queue depth (default 4 entries)
ACK_TIMEOUT, 16, cycles to wait in WAIT for en to drop before giving up (≥2)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst  input  1  synchronous reset, active-high
ev_valid  input  1  MPU event strobe, one event per cycle when high; no backpressure
ev_data  input  64  event payload, sampled when ev_valid=1
en  input  1  controller ready; 1 = can accept an irq
irq  output  1  one-cycle interrupt request to controller
data  output  64  payload of current/last issued event
level  output  DEPTH_LOG2+1  number of queued entries, 0..2^DEPTH_LOG2
overflow  output  1  sticky: an event was dropped because the queue was full
drop_cnt  output  16  saturating count of dropped events
ack_to  output  1  sticky: controller failed to drop en within ACK_TIMEOUT
clr_stat  input  1  clears overflow, drop_cnt, ack_to

Behaviour:
- Reset (sys_rst=1 at an edge): queue emptied (pointers 0, level 0); FSM to IDLE; irq=0, data=0, overflow=0, drop_cnt=0, ack_to=0, timeout counter 0. Reset mid-issue aborts the issue; queued entries are discarded.
- Queue: circular buffer, 2^DEPTH_LOG2 x 64. Pointers are DEPTH_LOG2+1 bits, so full and empty are distinguished by the MSB. Pointers wrap naturally.
- Push: ev_valid=1 and level < depth (evaluated before any same-cycle pop) writes ev_data at wr_ptr, and wr_ptr increments.
- ev_valid=1 while full drops the event, even if a pop occurs the same cycle. A dropped event sets overflow=1 and increments drop_cnt, saturating at 16'hFFFF.
- No bypass: an event written at edge N is eligible to issue in the cycle after edge N.
- level is registered and reflects push/pop at each edge. Simultaneous push and pop leave level unchanged.
- FSM states are IDLE, IRQ and WAIT.
- IDLE: if level≠0 and en=1 at the edge → data<=head entry, irq<=1, rd_ptr increments (pop), go to IRQ. Otherwise stay; irq=0.
- IRQ: irq=1 for exactly this one cycle. At the next edge: irq<=0, timeout counter<=0, go to WAIT.
- WAIT: if en=0 at an edge → go to IDLE. Otherwise the counter increments. When the counter reaches ACK_TIMEOUT-1 with en still 1 → ack_to<=1, go to IDLE; the event is considered delivered and is not re-queued.
- IDLE after WAIT issues again only once en=1. Consequently back-to-back events are spaced by the controller's en-low window.
- data holds its value from the IRQ cycle until the next issue; it is never cleared except by reset.
- Nominal timing with a controller that drops en the cycle after sampling irq:
  - Event written at edge E.
  - irq high in cycle after edge E+1.
  - WAIT entered at E+2, en=0 seen at E+3.
  - Next issue no earlier than the first edge with en=1.
- clr_stat=1: clears overflow, drop_cnt and ack_to. If a drop or timeout occurs in the same cycle, it is applied after the clear: drop_cnt=1 with overflow=1, or ack_to=1.
- irq is never asserted while en=0. irq is never asserted in two consecutive cycles.

Test Plan:
1. Reset, then one event ev_data=64'hDEAD_BEEF_0000_0001 with en=1 held, controller model drops en 1 cycle after irq for 4 cycles → irq high exactly one cycle two cycles after push; data=64'hDEAD_BEEF_0000_0001; level returns 0.
2. Burst of 6 consecutive ev_valid cycles (payloads 1..6), en=0 throughout → first 4 stored, level=4, overflow=1, drop_cnt=2. Then run the controller model → irq pulses carry 1,2,3,4 in order, each only after en returned to 1.
3. Queue full and ev_valid coincident with a pop in IDLE → event dropped, drop_cnt increments, level goes 4→3.
4. en held 1 permanently (dead controller), one event → irq once, ack_to=1 after 16 cycles in WAIT, FSM back to IDLE. A second queued event issues immediately.
5. sys_rst asserted in the IRQ cycle with 3 entries queued → next cycle irq=0, data=0, level=0, all stats 0. No further irq without new events.
6. drop_cnt preloaded to 16'hFFFF via 65535 drops, one more drop → stays FFFF. clr_stat with a simultaneous drop → drop_cnt=1, overflow=1.

Source files
------------

// File: rtl/mpu_irq_queue.sv
// mpu_irq_queue: buffers MPU interrupt events and issues them one at a time to the interrupt controller
// sys_clk/sys_rst: clock, synchronous active-high reset
// ev_valid/ev_data: event strobe and payload from the datapath (no backpressure)
// en: controller ready; irq/data: one-cycle request and payload of the last issued event
// level: queued entries; overflow/drop_cnt: sticky drop flag and saturating drop count
// ack_to: sticky flag, controller never dropped en after an irq; clr_stat clears the statistics
module mpu_irq_queue #(
  parameter int DEPTH_LOG2  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  ev_valid,
  input  logic [63:0]           ev_data,
  input  logic                  en,
  input  logic                  clr_stat,
  output logic                  irq,
  output logic [63:0]           data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  output logic                  ack_to
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = $clog2(ACK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, IRQ, WAIT} state_t;
  state_t state, state_nxt;
  logic [63:0] mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [CW-1:0] to_cnt;
  logic full, push, pop, drop, timeout;
  // level never exceeds DEPTH, so its MSB alone marks the queue full
  always_comb begin
    full = level[DEPTH_LOG2];
    push = ev_valid & ~full;
    drop = ev_valid & full;
    pop = state == IDLE && level != '0 && en;
    timeout = state == WAIT && en && to_cnt == CW'(ACK_TIMEOUT - 1);
    state_nxt = state == IDLE ? (pop ? IRQ : IDLE) :
                state == IRQ  ? WAIT :
                state == WAIT ? ((!en || timeout) ? IDLE : WAIT) : IDLE;
  end
  always_ff @(posedge sys_clk)
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= ev_data;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      to_cnt <= '0;
      irq <= 1'b0;
      data <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      ack_to <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(push);
      rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(pop);
      level <= level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      to_cnt <= state == IRQ ? '0 : state == WAIT ? to_cnt + 1'b1 : to_cnt;
      irq <= pop;
      if (pop) data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      // a drop or timeout in the clearing cycle survives the clear
      overflow <= (overflow & ~clr_stat) | drop;
      drop_cnt <= clr_stat ? {15'd0, drop} : drop_cnt + {15'd0, drop && drop_cnt != 16'hFFFF};
      ack_to <= (ack_to & ~clr_stat) | timeout;
    end
  end
endmodule

// File: tb/tb_mpu_irq_queue.sv
// tb_mpu_irq_queue: queue-based reference model with per-cycle compare plus directed literal checks
module tb_mpu_irq_queue;
  logic sys_clk = 0, sys_rst = 1, ev_valid = 0, clr_stat = 0;
  logic [63:0] ev_data = '0;
  logic en, irq, overflow, ack_to;
  logic [63:0] data;
  logic [2:0] level;
  logic [15:0] drop_cnt;
  int ctl = 0, low_cnt = 0, cyc = 0, checks = 0, errors = 0, e = 0;
  bit irq_seen = 0;
  logic [63:0] q[$], pulses[$];
  int irq_cycles[$];
  bit m_live = 0, m_irq = 0, m_ovf = 0, m_ack = 0, issue, lost, gave_up;
  logic [63:0] m_data = '0;
  int m_drop = 0, phase = 0, waited = 0;
  mpu_irq_queue dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ev_valid(ev_valid), .ev_data(ev_data),
    .en(en), .clr_stat(clr_stat), .irq(irq), .data(data), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .ack_to(ack_to)
  );
  always #5 sys_clk = ~sys_clk;
  assign en = ctl == 2 ? low_cnt == 0 : ctl == 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge sys_clk) begin
    if (irq_seen) low_cnt = 4;
    else if (low_cnt > 0) low_cnt--;
    irq_seen = irq === 1'b1;
  end
  always @(posedge sys_clk) begin
    cyc++;
    if (sys_rst) begin
      q.delete();
      m_live = 1; m_irq = 0; m_data = '0; m_ovf = 0; m_drop = 0; m_ack = 0; phase = 0; waited = 0;
    end else begin
      issue = phase == 0 && q.size() > 0 && en;
      lost = ev_valid && q.size() == 4;
      gave_up = phase == 2 && en && waited == 15;
      m_irq = issue;
      if (issue) begin
        m_data = q.pop_front();
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
        waited = 0;
      end else if (phase == 2) begin
        if (!en || gave_up) phase = 0;
        else waited++;
      end
      if (ev_valid && !lost) q.push_back(ev_data);
      m_ovf = (m_ovf && !clr_stat) || lost;
      m_ack = (m_ack && !clr_stat) || gave_up;
      m_drop = clr_stat ? int'(lost) : (lost && m_drop < 65535) ? m_drop + 1 : m_drop;
    end
  end
  always @(negedge sys_clk) if (m_live) begin
    chk("irq", irq, m_irq);
    chk("data", data, m_data);
    chk("level", level, q.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("ack_to", ack_to, m_ack);
    if (irq === 1'b1) begin
      pulses.push_back(data);
      irq_cycles.push_back(cyc);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1; ev_valid = 0; clr_stat = 0;
    @(negedge sys_clk);
    sys_rst = 0;
    pulses.delete();
    irq_cycles.delete();
  endtask
  task automatic push(input logic [63:0] v);
    @(negedge sys_clk);
    ev_valid = 1; ev_data = v;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    do_reset();
    ctl = 2;
    push(64'hDEAD_BEEF_0000_0001);
    @(negedge sys_clk);
    ev_valid = 0; e = cyc;
    tick(14);
    chk("t1_pulse_count", pulses.size(), 1);
    chk("t1_irq_cycle", irq_cycles.size() > 0 ? irq_cycles[0] : -1, e + 1);
    chk("t1_irq_data", pulses.size() > 0 ? pulses[0] : '0, 64'hDEAD_BEEF_0000_0001);
    chk("t1_level", level, 0);
    chk("t1_ack_to", ack_to, 0);
    do_reset();
    ctl = 0;
    for (int i = 1; i <= 6; i++) push(i);
    @(negedge sys_clk);
    ev_valid = 0;
    chk("t2_level", level, 4);
    chk("t2_overflow", overflow, 1);
    chk("t2_drop_cnt", drop_cnt, 2);
    @(negedge sys_clk);
    ctl = 2; ev_valid = 1; ev_data = 64'd7;
    @(negedge sys_clk);
    ev_valid = 0;
    chk("t3_level", level, 3);
    chk("t3_drop_cnt", drop_cnt, 3);
    chk("t3_irq", irq, 1);
    tick(40);
    chk("t2_pulse_count", pulses.size(), 4);
    for (int i = 0; i < 4 && i < pulses.size(); i++) chk("t2_order", pulses[i], i + 1);
    for (int i = 1; i < 4 && i < irq_cycles.size(); i++) chk("t2_spacing", irq_cycles[i] - irq_cycles[i-1], 6);
    do_reset();
    ctl = 1;
    push(64'hA);
    push(64'hB);
    e = cyc;
    @(negedge sys_clk);
    ev_valid = 0;
    tick(16);
    chk("t4_ack_to_early", ack_to, 0);
    tick(1);
    chk("t4_ack_to", ack_to, 1);
    tick(1);
    chk("t4_second_irq", irq, 1);
    chk("t4_second_data", data, 64'hB);
    chk("t4_first_cycle", irq_cycles.size() > 0 ? irq_cycles[0] : -1, e + 1);
    tick(25);
    do_reset();
    ctl = 0;
    for (int i = 10; i < 14; i++) push(i);
    @(negedge sys_clk);
    ev_valid = 0; ctl = 1;
    for (int i = 0; i < 10 && irq !== 1'b1; i++) @(negedge sys_clk);
    chk("t5_irq_seen", irq, 1);
    chk("t5_level_before", level, 3);
    sys_rst = 1;
    @(negedge sys_clk);
    sys_rst = 0;
    chk("t5_irq", irq, 0);
    chk("t5_data", data, 0);
    chk("t5_level", level, 0);
    chk("t5_stats", {overflow, ack_to, drop_cnt}, 0);
    pulses.delete();
    tick(30);
    chk("t5_no_irq", pulses.size(), 0);
    do_reset();
    ctl = 0;
    @(negedge sys_clk);
    ev_valid = 1; ev_data = 64'h55;
    tick(4 + 65535);
    chk("t6_saturate", drop_cnt, 16'hFFFF);
    tick(1);
    chk("t6_stay", drop_cnt, 16'hFFFF);
    clr_stat = 1;
    @(negedge sys_clk);
    clr_stat = 0;
    chk("t6_clr_drop_cnt", drop_cnt, 1);
    chk("t6_clr_overflow", overflow, 1);
    ev_valid = 0; clr_stat = 1;
    @(negedge sys_clk);
    clr_stat = 0;
    chk("t6_clr_only", {overflow, drop_cnt}, 0);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
